// File: rtl/nonce_tx_framer_pkg.sv
// Shared definitions for the nonce transmit framer: FSM encoding, frame
// constants and the byte-select helper used to build each frame byte.
`timescale 1ns/1ps
package nonce_tx_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Index of the final byte of a frame (nonce LSB).
    localparam logic [2:0] FRAME_LAST        = 3'd4;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Byte 0 is the sync header, bytes 1..4 are the nonce MSB first.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [31:0] word,
                                              input logic [7:0]  sync);
        logic [7:0] b;
        case (idx)
            3'd0:    b = sync;
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nonce_tx_framer_word_fifo.sv
// Small synchronous FIFO with registered read data and registered
// full/empty flags. Pointers carry one extra MSB to tell full from empty.
`timescale 1ns/1ps
module word_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr, rd_ptr;
    logic [ADDR_W:0]  wr_ptr_nxt, rd_ptr_nxt;
    logic             do_push, do_pop;

    // A push while full is refused here as well, so the storage is never
    // overwritten even if the caller forgets to gate it.
    assign do_push    = push & ~full;
    assign do_pop     = pop & ~empty;
    assign wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, do_push};
    assign rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, do_pop};

    // Pointer and flag registers; flags are derived from the next pointers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                      (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
        end
    end

    // Storage write.
    // NOTE: the array has no reset; the empty flag guarantees stale
    // contents are never read, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Registered read port: data appears the cycle after a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (do_pop) begin
            rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

endmodule

// File: rtl/nonce_tx_framer.sv
// Buffers golden-nonce strobes and serialises each one into a byte frame
// (optional sync byte, then the nonce MSB first) for the UART transmitter,
// honouring its new_data/busy handshake.
`timescale 1ns/1ps
module nonce_tx_framer
    import nonce_tx_framer_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter int         ADDR_W    = 2,
    parameter bit         SYNC_EN   = 1'b1,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] nonce,
    input  logic        nonce_valid,
    output logic        fifo_full,
    output logic [7:0]  drop_cnt,
    output logic        frame_busy,
    output logic [7:0]  tx_data,
    output logic        tx_new_data,
    input  logic        tx_busy
);

    localparam logic [2:0] FIRST_IDX = SYNC_EN ? 3'd0 : 3'd1;

    state_t      state, state_nxt;
    logic        push, pop, fifo_empty;
    logic [31:0] fifo_rd_data;
    logic [31:0] word_q;
    logic [2:0]  byte_idx;

    // Full is registered, so a pop in the same cycle does not make room.
    assign push       = nonce_valid & ~fifo_full;
    assign frame_busy = (state != ST_IDLE) | ~fifo_empty;

    word_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (nonce),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Saturating count of strobes that arrived while the FIFO was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'h00;
        end else if (nonce_valid && fifo_full && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, FIFO pop and the issue pulse to the transmitter.
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        tx_new_data = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: begin
                tx_new_data = ~tx_busy;
                if (!tx_busy) begin
                    state_nxt = ST_GAP;
                end
            end
            // One idle cycle lets the transmitter's busy reflect the issue.
            ST_GAP: state_nxt = (byte_idx == FRAME_LAST) ? ST_IDLE : ST_SEND;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame datapath: latch the word, step the byte index, and present the
    // next byte on tx_data before SEND so it is stable for the whole state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= 32'h0;
            byte_idx <= 3'd0;
            tx_data  <= 8'h00;
        end else begin
            case (state)
                ST_LOAD: begin
                    word_q   <= fifo_rd_data;
                    byte_idx <= FIRST_IDX;
                    tx_data  <= frame_byte(FIRST_IDX, fifo_rd_data, SYNC_BYTE);
                end
                ST_GAP: begin
                    if (byte_idx != FRAME_LAST) begin
                        byte_idx <= byte_idx + 3'd1;
                        tx_data  <= frame_byte(byte_idx + 3'd1, word_q, SYNC_BYTE);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
